// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
// Handshake: input i's head flit transfers exactly in a cycle where reqValid[i] && grant[i];
// output o carries that flit when outValid[o], which is only raised while outReady[o] is high.
interface switch_allocator_if #(
  parameter int PORT_NUM  = 5,
  parameter int SEL_WIDTH = 3
);
  logic [PORT_NUM-1:0]                reqValid;
  logic [PORT_NUM-1:0][SEL_WIDTH-1:0] reqDest;
  logic [PORT_NUM-1:0]                reqTail;
  logic [PORT_NUM-1:0]                outReady;
  logic [PORT_NUM-1:0]                grant;
  logic [PORT_NUM-1:0][SEL_WIDTH-1:0] sel;
  logic [PORT_NUM-1:0]                outValid;

  modport master (
    output reqValid, reqDest, reqTail, outReady,
    input  grant, sel, outValid
  );

  modport slave (
    input  reqValid, reqDest, reqTail, outReady,
    output grant, sel, outValid
  );
endinterface

// File: rtl/switch_allocator.sv
// Round-robin switch allocator with per-output wormhole lock; zero-cycle grant/select.
// Optional SWITCH_ALLOC_STALL_CNT_EN adds saturating per-output stall counters (stallCount).
module switch_allocator #(
  parameter int                     PORT_NUM  = 5,
  parameter int                     SEL_WIDTH = 3,
  parameter logic [SEL_WIDTH-1:0]   IDLE_SEL  = 3'b101
) (
  input  logic                          clk,
  input  logic                          reset,
  switch_allocator_if.slave             bus
`ifdef SWITCH_ALLOC_STALL_CNT_EN
  ,
  output logic [PORT_NUM-1:0][15:0]     stallCount
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Whole per-output state in one struct so checkers can bind to a single signal.
  typedef struct packed {
    lock_state_e          state;
    logic [SEL_WIDTH-1:0] owner;
    logic [SEL_WIDTH-1:0] rr_ptr;
  } out_state_t;

  localparam logic [SEL_WIDTH-1:0] RR_RESET = SEL_WIDTH'(PORT_NUM - 1);

  out_state_t [PORT_NUM-1:0]          out_state_q;
  out_state_t [PORT_NUM-1:0]          out_state_d;

  logic [PORT_NUM-1:0]                grant_c;
  logic [PORT_NUM-1:0][SEL_WIDTH-1:0] sel_c;
  logic [PORT_NUM-1:0]                out_valid_c;

`ifdef SWITCH_ALLOC_STALL_CNT_EN
  logic [PORT_NUM-1:0]                stall_hit;
  logic [PORT_NUM-1:0][15:0]          stall_cnt_q;
  logic [PORT_NUM-1:0][15:0]          stall_cnt_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        out_state_q[o].state  <= ST_IDLE;
        out_state_q[o].owner  <= '0;
        out_state_q[o].rr_ptr <= RR_RESET;
      end
    end else begin
      out_state_q <= out_state_d;
    end
  end

  always_comb begin : alloc
    logic [PORT_NUM-1:0]  req_vec;
    logic                 found;
    logic [SEL_WIDTH-1:0] win;
    logic [SEL_WIDTH-1:0] idx;

    grant_c     = '0;
    sel_c       = {PORT_NUM{IDLE_SEL}};
    out_valid_c = '0;
    out_state_d = out_state_q;
    req_vec     = '0;
    found       = 1'b0;
    win         = '0;
    idx         = '0;
`ifdef SWITCH_ALLOC_STALL_CNT_EN
    stall_hit   = '0;
`endif

    for (int o = 0; o < PORT_NUM; o++) begin
      // Out-of-range destinations never match any output, so they are silently ignored.
      for (int i = 0; i < PORT_NUM; i++) begin
        req_vec[i] = bus.reqValid[i] && (bus.reqDest[i] == SEL_WIDTH'(i - i + o));
      end

      found = 1'b0;
      win   = '0;

      case (out_state_q[o].state)
        ST_IDLE: begin
          for (int k = 1; k <= PORT_NUM; k++) begin
            idx = SEL_WIDTH'((int'(out_state_q[o].rr_ptr) + k) % PORT_NUM);
            if (!found && req_vec[idx]) begin
              found = 1'b1;
              win   = idx;
            end
          end
        end
        ST_LOCKED: begin
          if (req_vec[out_state_q[o].owner]) begin
            found = 1'b1;
            win   = out_state_q[o].owner;
          end
        end
        default: ;
      endcase

      if (found && bus.outReady[o]) begin
        grant_c[win]   = 1'b1;
        sel_c[o]       = win;
        out_valid_c[o] = 1'b1;
        if (out_state_q[o].state == ST_IDLE) begin
          out_state_d[o].rr_ptr = win;
          if (!bus.reqTail[win]) begin
            out_state_d[o].state = ST_LOCKED;
            out_state_d[o].owner = win;
          end
        end else if (bus.reqTail[win]) begin
          out_state_d[o].state = ST_IDLE;
        end
      end

`ifdef SWITCH_ALLOC_STALL_CNT_EN
      stall_hit[o] = (|req_vec) && !(found && bus.outReady[o]);
`endif
    end
  end

  // Reset dominates the combinational path so the crossbar is quiet while held.
  assign bus.grant    = reset ? '0 : grant_c;
  assign bus.outValid = reset ? '0 : out_valid_c;
  assign bus.sel      = reset ? {PORT_NUM{IDLE_SEL}} : sel_c;

`ifdef SWITCH_ALLOC_STALL_CNT_EN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (stall_hit[o] && (stall_cnt_q[o] != 16'hFFFF)) begin
        stall_cnt_d[o] = stall_cnt_q[o] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`endif

endmodule
